// File: rtl/cmos_capture.sv
// OV7670 DVP capture: waits for cfg_done, skips settling frames, packs byte pairs into RGB565 FIFO writes.
// Define CMOS_CAPTURE_TESTPAT_EN to replace pixel data with eight vertical colour bars.
module cmos_capture #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned SKIP_FRAMES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_done,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_db,
   input  logic        fifo_full,
   output logic        wr_en,
   output logic [15:0] wr_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        overflow,
   output logic        line_err,
   output logic        capturing
);

   typedef enum logic [1:0] {IDLE, WAIT_SYNC, SKIP, CAPTURE} state_t;

   localparam logic [9:0] H_LIM     = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM     = 10'(V_ACTIVE);
   localparam logic [7:0] SKIP_LAST = 8'(SKIP_FRAMES - 1);

   state_t      state, state_nx;
   logic        vs_r, hr_r, vs_d, hr_d;
   logic [7:0]  db_r, msb;
   logic        vs_fall, vs_rise, hr_fall;
   logic [7:0]  skip_cnt;
   logic        toggle;
   logic [9:0]  pix_cnt, line_cnt, lines_now;
   logic        frame_start_nx;
   logic [15:0] pix_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_r <= 1'b0;
         hr_r <= 1'b0;
         db_r <= '0;
         vs_d <= 1'b0;
         hr_d <= 1'b0;
      end else begin
         vs_r <= cmos_vsync;
         hr_r <= cmos_href;
         db_r <= cmos_db;
         vs_d <= vs_r;
         hr_d <= hr_r;
      end
   end

   assign vs_fall   = vs_d & ~vs_r;
   assign vs_rise   = ~vs_d & vs_r;
   assign hr_fall   = hr_d & ~hr_r;
   // A line ending on the same cycle as the vsync rise still counts toward the frame.
   assign lines_now = line_cnt + {9'b0, hr_fall};

`ifdef CMOS_CAPTURE_TESTPAT_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [2:0] bar;
   assign bar      = 3'(pix_cnt / BAR_W);
   assign pix_data = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
`else
   assign pix_data = {msb, db_r};
`endif

   always_comb begin
      state_nx       = state;
      frame_start_nx = 1'b0;
      case (state)
         IDLE:      if (cfg_done) state_nx = WAIT_SYNC;
         WAIT_SYNC: if (vs_fall) state_nx = SKIP;
         SKIP: begin
            if (vs_fall && skip_cnt == SKIP_LAST) begin
               state_nx       = CAPTURE;
               frame_start_nx = 1'b1;
            end
         end
         CAPTURE:   if (vs_fall) frame_start_nx = 1'b1;
         default:   state_nx = IDLE;
      endcase
      if (!cfg_done) begin
         state_nx       = IDLE;
         frame_start_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         skip_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == WAIT_SYNC)
            skip_cnt <= '0;
         else if (state == SKIP && vs_fall)
            skip_cnt <= skip_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en       <= 1'b0;
         wr_data     <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
         line_err    <= 1'b0;
         capturing   <= 1'b0;
         toggle      <= 1'b0;
         msb         <= '0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
      end else begin
         wr_en       <= 1'b0;
         frame_done  <= 1'b0;
         frame_start <= frame_start_nx;
         capturing   <= (state_nx == CAPTURE);
         if (state != CAPTURE || !cfg_done) begin
            toggle   <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
         end else begin
            toggle <= hr_r ? ~toggle : 1'b0;
            if (hr_r && !toggle)
               msb <= db_r;
            if (hr_r && toggle) begin
               if (pix_cnt != '1)
                  pix_cnt <= pix_cnt + 10'd1;
               if (pix_cnt < H_LIM) begin
                  if (fifo_full) begin
                     overflow <= 1'b1;
                  end else begin
                     wr_en   <= 1'b1;
                     wr_data <= pix_data;
                  end
               end
            end
            if (hr_fall) begin
               if (pix_cnt != H_LIM || toggle)
                  line_err <= 1'b1;
               pix_cnt <= '0;
               if (line_cnt != '1)
                  line_cnt <= line_cnt + 10'd1;
            end
            if (vs_rise) begin
               if (lines_now != V_LIM)
                  line_err <= 1'b1;
               frame_done <= 1'b1;
               line_cnt   <= '0;
            end
         end
      end
   end

endmodule
